inst_issue_queue: RTL and testbench

- Dual-slot instruction queue between fetch and ID.
- Accepts up to 2 fetched instructions per cycle and always presents the two oldest entries as issue pair A/B to the dual-issue controller.
- Retires 1 or 2 entries per cycle according to that controller's inst2_taken decision.
- Flushed on branch redirect or exception.

---
 rtl/inst_issue_queue.sv | 194 +++++++++++++++++++
 tb/tb_inst_issue_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// Dual-slot instruction queue between fetch and ID. It takes up to two fetched
// instructions per cycle and presents the two oldest entries as an issue pair.
module inst_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_valid,
  input  logic [ADDR_WIDTH-1:0]    push_pc0,
  input  logic [DATA_WIDTH-1:0]    push_inst0,
  input  logic [ADDR_WIDTH-1:0]    push_pc1,
  input  logic [DATA_WIDTH-1:0]    push_inst1,
  output logic                     push_ready,
  input  logic                     issue_ena,
  input  logic                     inst2_taken,
  output logic                     issue_valid_a,
  output logic [ADDR_WIDTH-1:0]    issue_pc_a,
  output logic [DATA_WIDTH-1:0]    issue_inst_a,
  output logic                     issue_valid_b,
  output logic [ADDR_WIDTH-1:0]    issue_pc_b,
  output logic [DATA_WIDTH-1:0]    issue_inst_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [PW-1:0] head_p1_s;
  logic [PW-1:0] tail_p1_s;
  logic [1:0]    push_num_s;
  logic [1:0]    pop_num_s;
  logic          wr0_s;
  logic          wr1_s;

  // Readiness looks only at the registered occupancy, never at this cycle's pop.
  always_comb begin
    push_ready    = (count_q <= CW'(DEPTH - 2));
    issue_valid_a = (count_q >= CW'(1));
    issue_valid_b = (count_q >= CW'(2));
    head_p1_s     = head_q + PW'(1);
    tail_p1_s     = tail_q + PW'(1);
    count         = count_q;
  end

  // Push amount: 01 -> one entry, 11 -> two entries, 10/00 -> nothing.
  always_comb begin
    push_num_s = 2'd0;
    if (push_ready) begin
      case (push_valid)
        2'b01:   push_num_s = 2'd1;
        2'b11:   push_num_s = 2'd2;
        default: push_num_s = 2'd0;
      endcase
    end else begin
      push_num_s = 2'd0;
    end
  end

  // Pop amount: inst2_taken only counts when B actually holds an entry.
  always_comb begin
    pop_num_s = 2'd0;
    if (issue_ena && issue_valid_a) begin
      if (inst2_taken && issue_valid_b) begin
        pop_num_s = 2'd2;
      end else begin
        pop_num_s = 2'd1;
      end
    end else begin
      pop_num_s = 2'd0;
    end
  end

  // Next-state pointers and occupancy; flush discards any same-cycle push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr0_s   = 1'b0;
    wr1_s   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_num_s);
      tail_d  = tail_q + PW'(push_num_s);
      count_d = count_q + CW'(push_num_s) - CW'(pop_num_s);
      wr0_s   = (push_num_s != 2'd0);
      wr1_s   = (push_num_s == 2'd2);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not cleared by reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (!rst && wr0_s) begin
      pc_mem[tail_q]   <= push_pc0;
      inst_mem[tail_q] <= push_inst0;
    end
    if (!rst && wr1_s) begin
      pc_mem[tail_p1_s]   <= push_pc1;
      inst_mem[tail_p1_s] <= push_inst1;
    end
  end

  // Issue pair read from head and head+1; invalid slots drive zero.
  always_comb begin
    issue_pc_a   = '0;
    issue_inst_a = '0;
    issue_pc_b   = '0;
    issue_inst_b = '0;
    if (issue_valid_a) begin
      issue_pc_a   = pc_mem[head_q];
      issue_inst_a = inst_mem[head_q];
    end else begin
      issue_pc_a   = '0;
      issue_inst_a = '0;
    end
    if (issue_valid_b) begin
      issue_pc_b   = pc_mem[head_p1_s];
      issue_inst_b = inst_mem[head_p1_s];
    end else begin
      issue_pc_b   = '0;
      issue_inst_b = '0;
    end
  end

  inst_issue_queue_chk #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .head  (head_q),
    .tail  (tail_q),
    .count (count_q)
  );

endmodule

// Simulation-only invariant checks on the queue bookkeeping.
module inst_issue_queue_chk #(
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  input logic [PW-1:0] head,
  input logic [PW-1:0] tail,
  input logic [CW-1:0] count
);

  logic [PW-1:0] span_s;

  // Distance from head to tail must always equal occupancy modulo DEPTH.
  always_comb begin
    span_s = tail - head;
  end

  // Occupancy bound and pointer consistency.
  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH))
        else $error("issue queue occupancy %0d exceeds depth", count);
      assert (span_s == count[PW-1:0])
        else $error("issue queue pointers inconsistent with occupancy %0d", count);
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: a queue-based reference model predicts
// the post-edge state, and an independent monitor compares after every edge.
module tb_inst_issue_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst, flush, issue_ena, inst2_taken;
  logic [1:0]    push_valid;
  logic [AW-1:0] push_pc0, push_pc1;
  logic [DW-1:0] push_inst0, push_inst1;
  logic          push_ready, issue_valid_a, issue_valid_b;
  logic [AW-1:0] issue_pc_a, issue_pc_b;
  logic [DW-1:0] issue_inst_a, issue_inst_b;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] pc_ctr = 32'h100;

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] inst; } ent_t;
  typedef struct {
    int cnt; logic va; logic vb; logic rdy;
    logic [AW-1:0] pa; logic [DW-1:0] ia; logic [AW-1:0] pb; logic [DW-1:0] ib;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];

  inst_issue_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
    .push_pc0(push_pc0), .push_inst0(push_inst0),
    .push_pc1(push_pc1), .push_inst1(push_inst1),
    .push_ready(push_ready), .issue_ena(issue_ena), .inst2_taken(inst2_taken),
    .issue_valid_a(issue_valid_a), .issue_pc_a(issue_pc_a), .issue_inst_a(issue_inst_a),
    .issue_valid_b(issue_valid_b), .issue_pc_b(issue_pc_b), .issue_inst_b(issue_inst_b),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies one clock edge to a plain FIFO and records the result.
  task automatic model_step();
    ent_t e, t;
    exp_t x;
    int   n;
    bit   rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    if (rst || flush) begin
      mq.delete();
    end else begin
      n = 0;
      if (issue_ena && mq.size() >= 1) n = (inst2_taken && mq.size() >= 2) ? 2 : 1;
      for (int i = 0; i < n; i++) t = mq.pop_front();
      if (rdy && (push_valid == 2'b01 || push_valid == 2'b11)) begin
        e.pc = push_pc0; e.inst = push_inst0; mq.push_back(e);
      end
      if (rdy && push_valid == 2'b11) begin
        e.pc = push_pc1; e.inst = push_inst1; mq.push_back(e);
      end
    end
    x.cnt = mq.size();
    x.va  = mq.size() >= 1;
    x.vb  = mq.size() >= 2;
    x.rdy = (DEPTH - mq.size()) >= 2;
    x.pa  = x.va ? mq[0].pc   : '0;
    x.ia  = x.va ? mq[0].inst : '0;
    x.pb  = x.vb ? mq[1].pc   : '0;
    x.ib  = x.vb ? mq[1].inst : '0;
    exp_q.push_back(x);
  endtask

  // One cycle of stimulus: drive, predict, then move past the edge.
  task automatic cyc(input logic r, input logic f, input logic [1:0] pv,
                     input logic ie, input logic i2);
    rst = r; flush = f; push_valid = pv; issue_ena = ie; inst2_taken = i2;
    push_pc0 = pc_ctr; push_pc1 = pc_ctr + 32'd4;
    push_inst0 = $urandom; push_inst1 = $urandom;
    model_step();
    if (!r && !f && push_ready && (pv == 2'b01 || pv == 2'b11))
      pc_ctr = pc_ctr + ((pv == 2'b11) ? 32'd8 : 32'd4);
    @(posedge clk);
    #2;
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count",   32'(count), 32'(x.cnt));
        chk("valid_a", 32'(issue_valid_a), 32'(x.va));
        chk("valid_b", 32'(issue_valid_b), 32'(x.vb));
        chk("ready",   32'(push_ready), 32'(x.rdy));
        chk("pc_a",    issue_pc_a, x.pa);
        chk("inst_a",  issue_inst_a, x.ia);
        chk("pc_b",    issue_pc_b, x.pb);
        chk("inst_b",  issue_inst_b, x.ib);
      end
    end
  end

  initial begin
    // Reset then idle.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    // Dual push, then single issue.
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    // Dual issue with a concurrent dual push; illegal 10 pattern.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    pc_ctr = 32'h200;
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    // Fill to 7, push dropped, single pop restores readiness.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    // Wrap: walk head to index 7 with two entries, then dual pop across the end.
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    // Flush beats push and pop; inst2_taken with one entry pops only one.
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    // Randomized traffic, including illegal patterns, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
